// File: rtl/id_pkg.sv
// id_pkg: shared decode definitions for the instruction-decode stage.
//   - RV32 base opcodes handled by the stage
//   - ALUOp class encodings
//   - immediate-format enumeration and decoded-control bundle
//   - decode_op(): opcode -> control bundle
//   - imm32():     immediate fields -> 32-bit immediate (before XLEN extension)
package id_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_B    = 2'd3
    } imm_type_e;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       result_src;
        logic       branch;
        logic [1:0] alu_op;
        imm_type_e  imm_type;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [6:0] opcode);
        ctrl_t c;
        c          = '0;
        c.imm_type = IMM_NONE;
        case (opcode)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            OP_ITYPE: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
                c.imm_type  = IMM_I;
            end
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.result_src = 1'b1;
                c.alu_op     = ALUOP_ADD;
                c.imm_type   = IMM_I;
            end
            OP_STORE: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
                c.imm_type  = IMM_S;
            end
            OP_BRANCH: begin
                c.branch   = 1'b1;
                c.alu_op   = ALUOP_BRANCH;
                c.imm_type = IMM_B;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // hi = instruction[31:20], lo = instruction[11:7]
    function automatic logic [31:0] imm32(input logic [11:0] hi,
                                          input logic [4:0]  lo,
                                          input imm_type_e   t);
        logic [31:0] v;
        case (t)
            IMM_I:   v = {{20{hi[11]}}, hi};
            IMM_S:   v = {{20{hi[11]}}, hi[11:5], lo};
            IMM_B:   v = {{19{hi[11]}}, hi[11], lo[0], hi[10:5], lo[4:1], 1'b0};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: architectural register file for the decode stage.
//   clk, rst          clock, asynchronous active-high reset (clears all entries)
//   wr_en/wr_idx/wr_data  synchronous write port; x0 and indices >= NREG ignored
//   rd_idx_a/rd_data_a    asynchronous read port A (x0 and out-of-range read 0)
//   rd_idx_b/rd_data_b    asynchronous read port B (x0 and out-of-range read 0)
module id_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [4:0]      wr_idx,
    input  logic [XLEN-1:0] wr_data,
    input  logic [4:0]      rd_idx_a,
    output logic [XLEN-1:0] rd_data_a,
    input  logic [4:0]      rd_idx_b,
    output logic [XLEN-1:0] rd_data_b
);

    localparam int         IW     = $clog2(NREG);
    localparam logic [5:0] NREG_L = 6'(NREG);

    logic [XLEN-1:0] regs [NREG];

    function automatic logic live(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < NREG_L);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en && live(wr_idx)) begin
            regs[wr_idx[IW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (live(rd_idx_a)) rd_data_a = regs[rd_idx_a[IW-1:0]];
        if (live(rd_idx_b)) rd_data_b = regs[rd_idx_b[IW-1:0]];
    end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I/RV32E instruction-decode stage with a one-entry
// valid/ready output register.
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        upstream handshake (in_ready = !out_valid || out_ready)
//   instruction, pc          raw instruction and its address
//   flush                    drops the held bundle and any same-cycle input
//   wb_en/wb_rd/wb_data      register write-back port
//   out_valid/out_ready      downstream handshake
//   RegWrite..Branch, ALUOp  decoded controls
//   dataA, dataB, imm_ext    operands and sign-extended immediate
//   rd, rs1, rs2, pc_out     register indices and pc of the bundle
//   illegal                  unknown opcode or register index >= NREG
// Build option: define ID_WB_BYPASS_EN to let an operand read of a register
// being written in the same cycle capture wb_data (write-first). Without it
// the old register contents are captured.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            RegWrite,
    output logic            ALUSrc,
    output logic            MemWrite,
    output logic            MemRead,
    output logic            ResultSrc,
    output logic            Branch,
    output logic [1:0]      ALUOp,
    output logic [XLEN-1:0] dataA,
    output logic [XLEN-1:0] dataB,
    output logic [XLEN-1:0] imm_ext,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);

    localparam logic [5:0] NREG_L = 6'(NREG);

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < NREG_L;
    endfunction

    logic [4:0]        f_rd, f_rs1, f_rs2;
    ctrl_t             dec;
    logic              bad;
    logic signed [31:0] imm_s;
    logic [XLEN-1:0]   imm_x, rf_a, rf_b, op_a, op_b;
    logic              hit_q_a, hit_q_b;
    logic              unused_funct3;

    assign f_rd  = instruction[11:7];
    assign f_rs1 = instruction[19:15];
    assign f_rs2 = instruction[24:20];
    assign unused_funct3 = ^instruction[14:12];

    assign dec = decode_op(instruction[6:0]);
    // Out-of-range indices only occur for NREG=16; the raw fields are checked.
    assign bad = dec.illegal || !in_range(f_rd) || !in_range(f_rs1) || !in_range(f_rs2);

    assign imm_s = signed'(imm32(instruction[31:20], instruction[11:7],
                                 bad ? IMM_NONE : dec.imm_type));
    assign imm_x = XLEN'(imm_s);

    id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wb_en),
        .wr_idx   (wb_rd),
        .wr_data  (wb_data),
        .rd_idx_a (f_rs1),
        .rd_data_a(rf_a),
        .rd_idx_b (f_rs2),
        .rd_data_b(rf_b)
    );

`ifdef ID_WB_BYPASS_EN
    logic hit_in_a, hit_in_b;
    assign hit_in_a = wb_en && (wb_rd == f_rs1) && (f_rs1 != 5'd0) && in_range(f_rs1);
    assign hit_in_b = wb_en && (wb_rd == f_rs2) && (f_rs2 != 5'd0) && in_range(f_rs2);
    assign op_a = hit_in_a ? wb_data : rf_a;
    assign op_b = hit_in_b ? wb_data : rf_b;
`else
    assign op_a = rf_a;
    assign op_b = rf_b;
`endif

    // A held bundle must not go stale while stalled: track writes to its sources.
    assign hit_q_a = wb_en && (wb_rd == rs1) && (rs1 != 5'd0) && in_range(rs1);
    assign hit_q_b = wb_en && (wb_rd == rs2) && (rs2 != 5'd0) && in_range(rs2);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            RegWrite  <= 1'b0;
            ALUSrc    <= 1'b0;
            MemWrite  <= 1'b0;
            MemRead   <= 1'b0;
            ResultSrc <= 1'b0;
            Branch    <= 1'b0;
            ALUOp     <= 2'b00;
            dataA     <= '0;
            dataB     <= '0;
            imm_ext   <= '0;
            rd        <= 5'd0;
            rs1       <= 5'd0;
            rs2       <= 5'd0;
            pc_out    <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            RegWrite  <= dec.reg_write  && !bad;
            ALUSrc    <= dec.alu_src    && !bad;
            MemWrite  <= dec.mem_write  && !bad;
            MemRead   <= dec.mem_read   && !bad;
            ResultSrc <= dec.result_src && !bad;
            Branch    <= dec.branch     && !bad;
            ALUOp     <= bad ? 2'b00 : dec.alu_op;
            dataA     <= op_a;
            dataB     <= op_b;
            imm_ext   <= imm_x;
            rd        <= f_rd;
            rs1       <= f_rs1;
            rs2       <= f_rs2;
            pc_out    <= pc;
            illegal   <= bad;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            if (hit_q_a) dataA <= wb_data;
            if (hit_q_b) dataB <= wb_data;
        end
    end

endmodule
